alu_rf_sequencer: RTL and testbench

Multi-cycle command sequencer that drives the register-file/ALU datapath (ALUAndRF) from a valid/ready command stream. It owns the Read1/Read2/WriteReg/RegWrite/WriteData/FuncCode/ALUOp side of that interface and consumes Zero/ALUOut. Each command is a load-immediate, a register-register ALU op with write-back, or a compare without write-back. The result and zero flag of every command are returned on a held response channel.

---
 rtl/alu_rf_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_rf_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rf_sequencer.sv
// Command sequencer for the ALUAndRF datapath: turns LI/ALU/CMP commands into
// read, execute and write-back cycles and returns each result on a held response.
module alu_rf_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [3:0]        cmd_funct,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [4:0]        Read1,
    output logic [4:0]        Read2,
    output logic [4:0]        WriteReg,
    output logic              RegWrite,
    output logic [DATA_W-1:0] WriteData,
    output logic [3:0]        FuncCode,
    output logic [1:0]        ALUOp,
    input  logic              Zero,
    input  logic [DATA_W-1:0] ALUOut,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  done_count
);

    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

    localparam logic [1:0] OP_LI  = 2'b00;
    localparam logic [1:0] OP_ALU = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;

    state_t              state_q;
    logic [1:0]          op_q;
    logic [4:0]          rd_q;
    logic [4:0]          read1_q;
    logic [4:0]          read2_q;
    logic [4:0]          wreg_q;
    logic                regwrite_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          func_q;
    logic [1:0]          aluop_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   result_q;
    logic                zero_q;
    logic                err_q;
    logic [CNT_W-1:0]    done_q;
    logic [CNT_W-1:0]    done_d;

    assign done_d = done_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            read1_q     <= '0;
            read2_q     <= '0;
            wreg_q      <= '0;
            regwrite_q  <= 1'b0;
            wdata_q     <= '0;
            func_q      <= '0;
            aluop_q     <= '0;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= '0;
        end else begin
            // Datapath strobes are one-cycle pulses; they fall back to 0 unless re-armed below.
            read1_q    <= '0;
            read2_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            wdata_q    <= '0;
            func_q     <= '0;
            aluop_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        err_q <= 1'b0;
                        case (cmd_op)
                            OP_LI: begin
                                state_q    <= WB;
                                result_q   <= cmd_imm;
                                zero_q     <= (cmd_imm == '0);
                                wreg_q     <= cmd_rd;
                                regwrite_q <= 1'b1;
                                wdata_q    <= cmd_imm;
                            end
                            OP_ALU, OP_CMP: begin
                                state_q <= EXEC;
                                read1_q <= cmd_rs;
                                read2_q <= cmd_rt;
                                aluop_q <= (cmd_op == OP_ALU) ? 2'b10 : 2'b01;
                                func_q  <= (cmd_op == OP_ALU) ? cmd_funct : 4'b0000;
                            end
                            default: begin
                                state_q     <= RESP;
                                result_q    <= '0;
                                zero_q      <= 1'b0;
                                err_q       <= 1'b1;
                                rsp_valid_q <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    result_q <= ALUOut;
                    zero_q   <= Zero;
                    if (op_q == OP_ALU) begin
                        state_q    <= WB;
                        wreg_q     <= rd_q;
                        regwrite_q <= 1'b1;
                        wdata_q    <= ALUOut;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WB: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        done_q      <= done_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign Read1      = read1_q;
    assign Read2      = read2_q;
    assign WriteReg   = wreg_q;
    assign RegWrite   = regwrite_q;
    assign WriteData  = wdata_q;
    assign FuncCode   = func_q;
    assign ALUOp      = aluop_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: a register-file/ALU datapath around the DUT and a
// shadow-register reference model that predicts every response.
module tb_alu_rf_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs, cmd_rt;
    logic [3:0]  cmd_funct;
    logic [31:0] cmd_imm;
    logic [4:0]  Read1, Read2, WriteReg;
    logic        RegWrite;
    logic [31:0] WriteData;
    logic [3:0]  FuncCode;
    logic [1:0]  ALUOp;
    logic        Zero;
    logic [31:0] ALUOut;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic [15:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_done = 0;

    logic [31:0] rf [32] = '{default: 32'h0};
    logic [31:0] sh [32] = '{default: 32'h0};
    logic [3:0]  fn_tab [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

    alu_rf_sequencer #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
        .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .RegWrite(RegWrite),
        .WriteData(WriteData), .FuncCode(FuncCode), .ALUOp(ALUOp),
        .Zero(Zero), .ALUOut(ALUOut),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: r0 hardwired to zero, write on the rising edge, combinational ALU.
    always @(posedge clk) begin
        if (RegWrite && WriteReg != 5'd0) rf[WriteReg] <= WriteData;
    end

    logic [31:0] a_env, b_env;
    always_comb begin
        a_env  = rf[Read1];
        b_env  = rf[Read2];
        ALUOut = a_env + b_env;
        case (ALUOp)
            2'b01: ALUOut = a_env - b_env;
            2'b10: begin
                case (FuncCode)
                    4'h0:    ALUOut = a_env & b_env;
                    4'h1:    ALUOut = a_env | b_env;
                    4'h2:    ALUOut = a_env + b_env;
                    4'h6:    ALUOut = a_env - b_env;
                    4'h7:    ALUOut = {31'd0, $signed(a_env) < $signed(b_env)};
                    4'hC:    ALUOut = ~(a_env | b_env);
                    default: ALUOut = 32'd0;
                endcase
            end
            default: ALUOut = a_env + b_env;
        endcase
        Zero = (ALUOut == 32'd0);
    end

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return (sa < sb) ? 32'd1 : 32'd0;
            4'hC: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [3:0] fn, input logic [31:0] imm,
                           input int hold, input string tag);
        logic [31:0] e_res;
        logic        e_zero, e_err;
        logic [1:0]  e_aop;
        logic [3:0]  e_fc;
        int e_lat, e_wr, e_ex, lat, wr_cnt, ex_cnt, wait_n;
        e_err = 1'b0;
        e_wr  = 0;
        e_ex  = 0;
        case (op)
            2'd0: begin e_res = imm; e_wr = 1; e_lat = 2; end
            2'd1: begin e_res = alu_ref(fn, sh[rs], sh[rt]); e_wr = 1; e_ex = 1; e_lat = 3; end
            2'd2: begin e_res = sh[rs] - sh[rt]; e_ex = 1; e_lat = 2; end
            default: begin e_res = 32'd0; e_err = 1'b1; e_lat = 1; end
        endcase
        e_zero = !e_err && (e_res == 32'd0);
        e_aop  = (op == 2'd1) ? 2'b10 : 2'b01;
        e_fc   = (op == 2'd1) ? fn : 4'h0;

        @(negedge clk);
        wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_funct = fn;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        if (hold == 0) cmd_valid = 1'b0;
        rsp_ready = (hold == 0);

        lat    = 0;
        wr_cnt = 0;
        ex_cnt = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (RegWrite) begin
                wr_cnt++;
                check({tag, "_wreg"}, 64'(WriteReg), 64'(rd));
                check({tag, "_wdata"}, 64'(WriteData), 64'(e_res));
            end else begin
                check({tag, "_wr_idle"}, 64'({WriteReg, WriteData}), 64'(0));
            end
            if (ALUOp != 2'b00) begin
                ex_cnt++;
                check({tag, "_read"}, 64'({Read1, Read2}), 64'({rs, rt}));
                check({tag, "_aluop"}, 64'({ALUOp, FuncCode}), 64'({e_aop, e_fc}));
            end else begin
                check({tag, "_rd_idle"}, 64'({Read1, Read2, FuncCode}), 64'(0));
            end
            if (rsp_valid) lat = n;
        end
        check({tag, "_latency"}, 64'(lat), 64'(e_lat));
        check({tag, "_result"}, 64'(rsp_result), 64'(e_res));
        check({tag, "_zero_err"}, 64'({rsp_zero, rsp_err}), 64'({e_zero, e_err}));
        check({tag, "_regwrites"}, 64'(wr_cnt), 64'(e_wr));
        check({tag, "_exec_cycles"}, 64'(ex_cnt), 64'(e_ex));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_held"}, 64'({rsp_valid, rsp_zero, rsp_err, rsp_result}),
                  64'({1'b1, e_zero, e_err, e_res}));
            check({tag, "_held_ctl"}, 64'({cmd_ready, RegWrite}), 64'(0));
        end
        if (hold > 0) begin
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_done = (exp_done + 1) % 65536;
        if (e_wr == 1 && rd != 5'd0) sh[rd] = e_res;
        check({tag, "_done"}, 64'(done_count), 64'(exp_done));
        check({tag, "_after"}, 64'({rsp_valid, cmd_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_rd    = 5'd0;
        cmd_rs    = 5'd0;
        cmd_rt    = 5'd0;
        cmd_funct = 4'd0;
        cmd_imm   = 32'd0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'({rsp_valid, rsp_zero, rsp_err, RegWrite, ALUOp, done_count}), 64'(0));
        check("reset_result", 64'(rsp_result), 64'(0));
        check("reset_dp", 64'({Read1, Read2, WriteReg, WriteData, FuncCode}), 64'(0));
        check("reset_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        run_cmd(2'd0, 5'd5, 5'd0, 5'd0, 4'h0, 32'h5555_5555, 0, "li_r5");
        run_cmd(2'd0, 5'd10, 5'd0, 5'd0, 4'h0, 32'hAAAA_AAAA, 0, "li_r10");
        run_cmd(2'd1, 5'd3, 5'd5, 5'd10, 4'h0, 32'd0, 0, "alu_and");
        run_cmd(2'd1, 5'd4, 5'd5, 5'd10, 4'h1, 32'd0, 0, "alu_or");
        run_cmd(2'd1, 5'd4, 5'd5, 5'd10, 4'h2, 32'd0, 0, "alu_add");
        check("r4_value", 64'(rf[4]), 64'(32'hFFFF_FFFF));
        check("r3_value", 64'(rf[3]), 64'(0));
        run_cmd(2'd2, 5'd0, 5'd5, 5'd5, 4'h0, 32'd0, 0, "cmp_eq");
        run_cmd(2'd2, 5'd0, 5'd5, 5'd10, 4'h0, 32'd0, 0, "cmp_ne");
        run_cmd(2'd1, 5'd6, 5'd5, 5'd10, 4'h6, 32'd0, 10, "alu_hold");
        run_cmd(2'd3, 5'd9, 5'd1, 5'd2, 4'h0, 32'hDEAD_BEEF, 0, "reserved");

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  r_op;
            logic [31:0] r_imm;
            r_op  = 2'($urandom_range(0, 3));
            r_imm = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_cmd(r_op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), fn_tab[$urandom_range(0, 5)], r_imm,
                    int'($urandom_range(0, 3)), "random");
        end

        // Reset in the middle of the write-back cycle of LI r7.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_rd    = 5'd7;
        cmd_imm   = 32'h1234_5678;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("rst_wb_entered", 64'({RegWrite, WriteReg}), 64'({1'b1, 5'd7}));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_regwrite_drop", 64'({RegWrite, WriteData}), 64'(0));
        exp_done = 0;
        check("rst_done_clear", 64'({rsp_valid, done_count}), 64'(0));
        repeat (2) @(negedge clk);
        check("rst_no_rsp", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;
        run_cmd(2'd2, 5'd0, 5'd7, 5'd0, 4'h0, 32'd0, 0, "cmp_r7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
